// File: rtl/net_axis_framer_if.sv
// AXI-stream bus used on the output side of net_axis_framer.
// The framer drives it through the master modport; downstream logic uses slave.
interface net_axis_framer_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 7,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   logic [DEST_WIDTH-1:0] tdest;
   logic [ID_WIDTH-1:0]   tid;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata, tkeep, tlast, tuser, tdest, tid, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tlast, tuser, tdest, tid, tvalid,
      output tready
   );
endinterface

// File: rtl/net_axis_framer.sv
// Buffers row-packed core beats in a FIFO and emits AXI-stream frames with forced tlast,
// a per-frame sequence number on tuser and a constant tdest. Define NET_AXIS_FRAMER_STATS_EN for counters.
module net_axis_framer #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int ROWS            = 32,
   parameter int INPUT_LENGTH    = 16,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_ID_WIDTH   = 7,
   parameter int AXIS_DEST_WIDTH = 8,
   parameter int AXIS_USER_WIDTH = 8,
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_BEATS       = 64,
   parameter logic [AXIS_DEST_WIDTH-1:0] DEST_VALUE = 'hbf
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ROWS*INPUT_LENGTH-1:0]     net_data_in,
   input  logic                             net_valid_in,
   input  logic [AXIS_KEEP_WIDTH-1:0]       net_data_tkeep,
   input  logic                             net_data_tlast,
   output logic                             net_tx_rdy,
   net_axis_framer_if.master                m_net_axis,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
   output logic [31:0]                      stat_frames,
   output logic [31:0]                      stat_beats
);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int BW      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int ENTRY_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
   localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

   logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [AW:0]                level;
   logic [BW-1:0]              in_beat;
   logic [AXIS_USER_WIDTH-1:0] seq;
   logic                       accept_en;
   logic                       full;
   logic                       empty;
   logic                       push;
   logic                       pop;
   logic                       stored_last;
   logic [AXIS_DATA_WIDTH-1:0] head_data;
   logic [AXIS_KEEP_WIDTH-1:0] head_keep;
   logic                       head_last;

   // accept_en keeps the framer closed until the first edge after reset release
   assign full        = (level == FULL_LVL);
   assign empty       = (level == '0);
   assign net_tx_rdy  = accept_en & ~full;
   assign push        = net_valid_in & net_tx_rdy;
   assign pop         = ~empty & m_net_axis.tready;
   assign stored_last = net_data_tlast | (in_beat == LAST_BEAT);

   assign {head_data, head_keep, head_last} = mem[rd_ptr];

   assign m_net_axis.tdata  = head_data;
   assign m_net_axis.tkeep  = head_keep;
   assign m_net_axis.tlast  = head_last;
   assign m_net_axis.tuser  = seq;
   assign m_net_axis.tdest  = DEST_VALUE;
   assign m_net_axis.tid    = {AXIS_ID_WIDTH{1'b0}};
   assign m_net_axis.tvalid = ~empty;
   assign fifo_level        = level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_en <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         in_beat   <= '0;
         seq       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         accept_en <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= {AXIS_DATA_WIDTH'(net_data_in), net_data_tkeep, stored_last};
            wr_ptr      <= wr_ptr + 1'b1;
            in_beat     <= stored_last ? '0 : in_beat + 1'b1;
         end
         // seq advances only when a frame's final beat leaves, so tuser is constant per frame
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (head_last) seq <= seq + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

`ifdef NET_AXIS_FRAMER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames <= '0;
         stat_beats  <= '0;
      end else if (pop) begin
         stat_beats <= stat_beats + 32'd1;
         if (head_last) stat_frames <= stat_frames + 32'd1;
      end
   end
`else
   assign stat_frames = '0;
   assign stat_beats  = '0;
`endif
endmodule
